acc_predecoder_dispatch: RTL and testbench
==========================================

// Module: acc_predecoder_dispatch
// PURPOSE
// Parametrised, credit-tracked successor of the single-table offload predecoder.
// Accepts one offload instruction per handshake and matches it against a table of NumEntries
// {data, mask, prd_rsp, acc_idx} entries spanning NumAcc accelerators.
// Returns the predecoder response plus the target accelerator index.
// Sits between the core offload port and the accelerator interconnect; throttles offloads
// per accelerator with outstanding-instruction credits.
// PARAMETERS
// NumAcc          4                            accelerators served; AccIdxW = max(1, $clog2(NumAcc))
// NumEntries      8                            instruction-table entries
// MaxOutstanding  4                            credits per accelerator; CntW = $clog2(MaxOutstanding+1)
// InstrTable      '0                           acc_offload_entry_t [NumEntries-1:0]; decode table
// PORTS
// clk_i           in   1        clock
// rst_i           in   1        async reset, active-high
// flush_i         in   1        drop the held instruction (pipeline kill)
// q_valid_i       in   1        offload request valid
// q_ready_o       out  1        offload request ready
// q_instr_data_i  in   32       instruction word
// p_valid_o       out  1        response valid
// p_ready_i       in   1        response ready
// p_rsp_o         out  acc_prd_rsp_t  {p_accept, p_writeback[1:0], p_use_rs[2:0]}
// p_acc_idx_o     out  AccIdxW  target accelerator (0 when p_accept=0)
// acc_done_i      in   NumAcc   one-cycle pulse per retired instruction; returns 1 credit
// credit_err_o    out  1        sticky: credit returned to a full counter
// BEHAVIOUR
// - Reset values: state IDLE, p_valid_o=0, p_rsp_o='0, p_acc_idx_o=0, credit_err_o=0,
//   all credit counters = MaxOutstanding. q_ready_o=1 after reset.
// - Request handshake on q_valid_i & q_ready_o: instruction registered; decode runs on the register.
// - Match rule: (instr & mask) == data; the lowest-index matching entry wins.
// - FSM IDLE/RESP/STALL. q_ready_o = (state==IDLE) | (state==RESP & p_ready_i).
//   - IDLE --q hs--> RESP if no match or credit[acc]>0, else STALL.
//   - STALL --credit[acc]>0--> RESP. p_valid_o=0 in STALL.
//   - RESP --p hs & new q hs--> RESP/STALL (back-to-back); RESP --p hs only--> IDLE.
// - Latency: p_valid_o asserts the cycle after q handshake if not stalled (1 cycle, full throughput).
//   Response is stable while p_valid_o & !p_ready_i.
// - No match: p_accept=0, writeback=0, use_rs=0, acc_idx=0; no credit consumed.
// - Match: p_rsp_o = entry prd_rsp; credit[acc] decrements on the p handshake only when p_accept=1.
// - Credit arithmetic per acc: next = cnt - consume + done.
//   - Simultaneous consume and done: unchanged.
//   - done at cnt==MaxOutstanding with no consume: saturate and set credit_err_o.
//   - A done pulse during STALL releases the stall the following cycle.
// - flush_i: highest priority.
//   - Next state IDLE, p_valid_o=0 next cycle, no credit consumed even if p_ready_i is high.
//   - q_ready_o forced 0 that cycle; credits and acc_done_i still processed.
// - Reset mid-operation: held instruction discarded; credits restored to MaxOutstanding.
// STRUCTURE
// - acc_pkg: add acc_offload_entry_t {offload_instr_t instr; logic [7:0] acc_idx;}.
//   Reuse acc_prd_rsp_t; use maxn/sumn for derived localparams.
// - Sub-module acc_credit_counter (one per accelerator):
//   - Ports: consume_i, return_i, avail_o, err_o.
//   - Parameter: MaxOutstanding. Same clock and async active-high reset.
// - Table match: generate loop plus priority encoder in the top level.
// TESTING
// - Reset: rst_i pulse -> q_ready_o=1, p_valid_o=0, credit_err_o=0.
// - Decode: entry 2 {data=0x0000_000B, mask=0x0000_007F, acc=1}; request 0x1234_500B
//   -> next cycle p_valid_o=1, acc_idx=1, entry 2 rsp.
// - Miss: request 0xFFFF_FFFF (no match) -> p_accept=0, acc_idx=0, credits unchanged.
// - Credit exhaustion: 5 back-to-back acc-1 requests, p_ready_i=1, MaxOutstanding=4.
//   -> 4 responses; 5th stays in STALL. acc_done_i[1] pulse -> 5th response 1 cycle later.
// - Overlap: acc-1 consume and acc_done_i[1] in the same cycle -> counter unchanged.
//   done at full -> credit_err_o=1.
// - Flush: flush_i while RESP with p_ready_i=0 -> p_valid_o=0 next cycle, credit not consumed.
//   Then rst_i mid-STALL -> IDLE, credits=4.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared types and helpers for the accelerator offload predecoder/dispatcher.
package acc_pkg;

  typedef struct packed {
    logic       p_accept;
    logic [1:0] p_writeback;
    logic [2:0] p_use_rs;
  } acc_prd_rsp_t;

  typedef struct packed {
    logic [31:0]  data;
    logic [31:0]  mask;
    acc_prd_rsp_t prd_rsp;
  } offload_instr_t;

  typedef struct packed {
    offload_instr_t instr;
    logic [7:0]     acc_idx;
  } acc_offload_entry_t;

  function automatic int unsigned maxn(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned sumn(input int unsigned a, input int unsigned b);
    return a + b;
  endfunction

endpackage

// File: rtl/acc_credit_counter.sv
// Per-accelerator outstanding-instruction credit counter with sticky overflow flag.
module acc_credit_counter
  import acc_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic consume_i,
  input  logic return_i,
  output logic avail_o,
  output logic err_o
);

  localparam int unsigned CntW = $clog2(sumn(MaxOutstanding, 1));
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (consume_i && !return_i) begin
      if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
    end else if (return_i && !consume_i) begin
      if (cnt_q == CntMax) err_d = 1'b1;
      else                 cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= CntMax;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Looks at the post-update count so a return this cycle can release a waiter next cycle.
  assign avail_o = (cnt_d != '0);
  assign err_o   = err_q;

endmodule

// File: rtl/acc_predecoder_dispatch.sv
// Offload predecoder: table match on the incoming instruction, then a credit-throttled
// single-entry response stage routing each accepted instruction to its accelerator.
module acc_predecoder_dispatch
  import acc_pkg::*;
#(
  parameter int unsigned NumAcc         = 4,
  parameter int unsigned NumEntries     = 8,
  parameter int unsigned MaxOutstanding = 4,
  parameter acc_offload_entry_t [NumEntries-1:0] InstrTable = '0,
  localparam int unsigned AccIdxW = maxn(1, $clog2(NumAcc))
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               q_valid_i,
  output logic               q_ready_o,
  input  logic [31:0]        q_instr_data_i,
  output logic               p_valid_o,
  input  logic               p_ready_i,
  output acc_prd_rsp_t       p_rsp_o,
  output logic [AccIdxW-1:0] p_acc_idx_o,
  input  logic [NumAcc-1:0]  acc_done_i,
  output logic               credit_err_o
);

  localparam int unsigned AccSlots = 1 << AccIdxW;

  typedef enum logic [1:0] {S_IDLE, S_RESP, S_STALL} state_e;

  state_e              state_q;
  acc_prd_rsp_t        rsp_q;
  logic [AccIdxW-1:0]  acc_q;

  logic [NumEntries-1:0] match;
  acc_prd_rsp_t          dec_rsp;
  logic [AccIdxW-1:0]    dec_acc;
  logic [NumAcc-1:0]     avail, consume, cnt_err;
  logic [AccSlots-1:0]   avail_pad;
  logic                  q_hs, resp_fire, dec_go, held_go;

  for (genvar e = 0; e < NumEntries; e++) begin : g_match
    assign match[e] = (q_instr_data_i & InstrTable[e].instr.mask) == InstrTable[e].instr.data;
  end

  // Scan high to low so the lowest matching index is the one left standing.
  always_comb begin
    dec_rsp = '0;
    dec_acc = '0;
    for (int e = int'(NumEntries) - 1; e >= 0; e--) begin
      if (match[e]) begin
        dec_rsp = InstrTable[e].instr.prd_rsp;
        dec_acc = InstrTable[e].acc_idx[AccIdxW-1:0];
      end
    end
    if (!dec_rsp.p_accept) dec_acc = '0;
  end

  // Handshakes: a transfer happens on a cycle where valid & ready are both high; a producer
  // holding valid keeps its payload stable until that cycle. flush_i kills both sides.
  assign q_ready_o = !flush_i && ((state_q == S_IDLE) || ((state_q == S_RESP) && p_ready_i));
  assign q_hs      = q_valid_i && q_ready_o;
  assign resp_fire = (state_q == S_RESP) && p_ready_i && !flush_i;

  for (genvar a = 0; a < NumAcc; a++) begin : g_credit
    assign consume[a] = resp_fire && rsp_q.p_accept && (acc_q == AccIdxW'(a));
    acc_credit_counter #(
      .MaxOutstanding (MaxOutstanding)
    ) u_credit (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .consume_i (consume[a]),
      .return_i  (acc_done_i[a]),
      .avail_o   (avail[a]),
      .err_o     (cnt_err[a])
    );
  end

  always_comb begin
    avail_pad             = '0;
    avail_pad[NumAcc-1:0] = avail;
  end

  assign dec_go  = !dec_rsp.p_accept || avail_pad[dec_acc];
  assign held_go = avail_pad[acc_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      rsp_q   <= '0;
      acc_q   <= '0;
    end else if (flush_i) begin
      state_q <= S_IDLE;
      rsp_q   <= '0;
      acc_q   <= '0;
    end else if (q_hs) begin
      state_q <= dec_go ? S_RESP : S_STALL;
      rsp_q   <= dec_rsp;
      acc_q   <= dec_acc;
    end else begin
      case (state_q)
        S_RESP:  if (p_ready_i) state_q <= S_IDLE;
        S_STALL: if (held_go)   state_q <= S_RESP;
        default: ;
      endcase
    end
  end

  assign p_valid_o    = (state_q == S_RESP);
  assign p_rsp_o      = rsp_q;
  assign p_acc_idx_o  = acc_q;
  assign credit_err_o = |cnt_err;

endmodule

// File: tb/tb_acc_predecoder_dispatch.sv
// Bench for acc_predecoder_dispatch: decode vectors, credit/flush/reset sequences, random traffic.
module tb_acc_predecoder_dispatch;
  import acc_pkg::*;

  localparam int MAXO = 4;

  function automatic acc_offload_entry_t mk(input logic [31:0] d, input logic [31:0] m,
                                            input logic [5:0] r, input logic [7:0] a);
    acc_offload_entry_t e;
    e.instr.data    = d;
    e.instr.mask    = m;
    e.instr.prd_rsp = r;
    e.acc_idx       = a;
    return e;
  endfunction

  localparam acc_offload_entry_t [7:0] TABLE = {
    mk(32'h8000_0057, 32'hFFFF_FFFF, 6'b110000, 8'd2),
    mk(32'h0000_000F, 32'h0000_707F, 6'b101101, 8'd3),
    mk(32'h0000_007B, 32'h0000_007F, 6'b100110, 8'd0),
    mk(32'h0000_005B, 32'h0000_007F, 6'b111100, 8'd3),
    mk(32'h0000_100B, 32'h0000_707F, 6'b101010, 8'd3),
    mk(32'h0000_000B, 32'h0000_007F, 6'b110111, 8'd1),
    mk(32'h0000_002B, 32'h0000_007F, 6'b100001, 8'd2),
    mk(32'h0000_0033, 32'h0000_007F, 6'b101011, 8'd0)
  };

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic         q_valid = 1'b0;
  logic         q_ready;
  logic [31:0]  q_instr = '0;
  logic         p_valid;
  logic         p_ready = 1'b0;
  acc_prd_rsp_t p_rsp;
  logic [1:0]   p_acc;
  logic [3:0]   acc_done = '0;
  logic         credit_err;

  acc_predecoder_dispatch #(
    .NumAcc         (4),
    .NumEntries     (8),
    .MaxOutstanding (MAXO),
    .InstrTable     (TABLE)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .q_valid_i      (q_valid),
    .q_ready_o      (q_ready),
    .q_instr_data_i (q_instr),
    .p_valid_o      (p_valid),
    .p_ready_i      (p_ready),
    .p_rsp_o        (p_rsp),
    .p_acc_idx_o    (p_acc),
    .acc_done_i     (acc_done),
    .credit_err_o   (credit_err)
  );

  // ---- clock / watchdog ----
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- scoreboard ----
  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];
  int credits[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string why);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: %s", name, why);
  endtask

  // Reference decode: first table entry whose masked bits equal its data.
  function automatic logic [7:0] ref_decode(input logic [31:0] w);
    for (int e = 0; e < 8; e++) begin
      if ((w & TABLE[e].instr.mask) == TABLE[e].instr.data) begin
        if (TABLE[e].instr.prd_rsp.p_accept) return {TABLE[e].instr.prd_rsp, TABLE[e].acc_idx[1:0]};
        return {TABLE[e].instr.prd_rsp, 2'b00};
      end
    end
    return 8'h00;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 9))
      0: w[6:0] = 7'h33;
      1: w[6:0] = 7'h2B;
      2, 7, 8: w[6:0] = 7'h0B;
      3: w[6:0] = 7'h5B;
      4: begin w[6:0] = 7'h0F; w[14:12] = 3'b000; end
      5: w[6:0] = 7'h7B;
      6: w = 32'h8000_0057;
      default: ;
    endcase
    return w;
  endfunction

  // ---- driver tasks ----
  task automatic do_reset();
    q_valid = 1'b0; flush = 1'b0; p_ready = 1'b0; acc_done = '0; q_instr = '0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  exp_rsp;
    logic [1:0]  exp_acc;
  } vec_t;
  vec_t vecs[10];

  task automatic apply_vec(input vec_t v);
    @(negedge clk); q_valid = 1'b1; q_instr = v.instr; p_ready = 1'b1; #1;
    check("vec_q_ready", q_ready, 1);
    @(negedge clk); q_valid = 1'b0; #1;
    check("vec_p_valid", p_valid, 1);
    check("vec_rsp", p_rsp, v.exp_rsp);
    check("vec_acc", p_acc, v.exp_acc);
    @(negedge clk);
    if (v.exp_rsp[5]) acc_done = 4'b0001 << v.exp_acc;
    #1;
    check("vec_back_idle", p_valid, 0);
    @(negedge clk); acc_done = '0;
  endtask

  // Five back-to-back acc-1 requests: four responses, then the fifth waits for credit.
  task automatic exhaust();
    int hs, resp;
    hs = 0; resp = 0;
    q_instr = 32'h1234_500B; p_ready = 1'b1;
    for (int c = 0; c < 12 && hs < 5; c++) begin
      @(negedge clk); q_valid = 1'b1; #1;
      if (p_valid && p_ready) resp++;
      if (q_ready) hs++;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); q_valid = 1'b0; #1;
      if (p_valid && p_ready) resp++;
      check("stall_hold", p_valid, 0);
    end
    check("exhaust_handshakes", hs, 5);
    check("exhaust_responses", resp, 4);
  endtask

  // ---- test ----
  initial begin
    vecs[0] = '{32'h1234_500B, 6'b110111, 2'd1};
    vecs[1] = '{32'hFFFF_FFFF, 6'b000000, 2'd0};
    vecs[2] = '{32'h0000_0033, 6'b101011, 2'd0};
    vecs[3] = '{32'hABCD_E02B, 6'b100001, 2'd2};
    vecs[4] = '{32'h0000_100B, 6'b110111, 2'd1};
    vecs[5] = '{32'h0000_005B, 6'b111100, 2'd3};
    vecs[6] = '{32'h0000_000F, 6'b101101, 2'd3};
    vecs[7] = '{32'h8000_0057, 6'b110000, 2'd2};
    vecs[8] = '{32'h8000_0157, 6'b000000, 2'd0};
    vecs[9] = '{32'h1234_567B, 6'b100110, 2'd0};

    do_reset(); #1;
    check("reset_q_ready", q_ready, 1);
    check("reset_p_valid", p_valid, 0);
    check("reset_err", credit_err, 0);
    check("reset_rsp", {p_rsp, p_acc}, 0);

    foreach (vecs[i]) apply_vec(vecs[i]);
    check("vec_no_err", credit_err, 0);
    // acc 0 must be full again: misses must not have taken its credit
    @(negedge clk); acc_done = 4'b0001;
    @(negedge clk); acc_done = '0; #1;
    check("miss_no_consume", credit_err, 1);

    do_reset();
    exhaust();
    @(negedge clk); acc_done = 4'b0010; #1;
    check("release_same_cycle", p_valid, 0);
    @(negedge clk); acc_done = '0; #1;
    check("release_valid", p_valid, 1);
    check("release_rsp", {p_rsp, p_acc}, {6'b110111, 2'd1});
    @(negedge clk); #1;
    check("release_idle", p_valid, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); acc_done = 4'b0010;
    end
    @(negedge clk); acc_done = '0; #1;
    check("refill_no_err", credit_err, 0);

    do_reset();
    @(negedge clk); q_valid = 1'b1; q_instr = 32'h1234_500B; p_ready = 1'b1;
    @(negedge clk); q_valid = 1'b0; acc_done = 4'b0010; #1;
    check("overlap_valid", p_valid, 1);
    @(negedge clk); acc_done = '0; #1;
    check("overlap_no_err", credit_err, 0);
    @(negedge clk); acc_done = 4'b0010;
    @(negedge clk); acc_done = '0; #1;
    check("done_at_full_err", credit_err, 1);
    @(negedge clk); #1;
    check("err_sticky", credit_err, 1);

    do_reset();
    @(negedge clk); q_valid = 1'b1; q_instr = 32'h1234_500B; p_ready = 1'b0;
    @(negedge clk); q_valid = 1'b0; flush = 1'b1; #1;
    check("flush_pre_valid", p_valid, 1);
    check("flush_q_ready", q_ready, 0);
    @(negedge clk); flush = 1'b0; #1;
    check("flush_drop", p_valid, 0);
    @(negedge clk); q_valid = 1'b1; q_instr = 32'h1234_500B; p_ready = 1'b1;
    @(negedge clk); q_instr = 32'h0000_0033; flush = 1'b1; #1;
    check("flush_rdy_valid", p_valid, 1);
    check("flush_q_ready_forced", q_ready, 0);
    @(negedge clk); q_valid = 1'b0; flush = 1'b0; #1;
    check("flush_drop_rdy", p_valid, 0);
    @(negedge clk); acc_done = 4'b0010;
    @(negedge clk); acc_done = '0; #1;
    check("flush_no_consume", credit_err, 1);

    do_reset();
    exhaust();
    @(negedge clk); #2; rst = 1'b1; #1;
    check("rst_stall_p_valid", p_valid, 0);
    check("rst_stall_q_ready", q_ready, 1);
    check("rst_stall_err", credit_err, 0);
    @(negedge clk); rst = 1'b0; #1;
    check("rst_stall_dropped", p_valid, 0);
    exhaust();

    // Random traffic against the transaction-level model.
    do_reset();
    foreach (credits[a]) credits[a] = MAXO;
    exp_q.delete();
    begin
      logic       q_took, hold_pend, fin;
      logic [7:0] hold_val, exp;
      int         cyc;
      q_took = 1'b0; hold_pend = 1'b0; hold_val = '0; fin = 1'b0; cyc = 0;
      while (!fin) begin
        @(negedge clk);
        if (!q_valid || q_took) begin
          if (cyc < 500) begin
            q_valid = ($urandom_range(0, 3) != 0);
            q_instr = rand_instr();
          end else begin
            q_valid = 1'b0;
          end
        end
        p_ready = ($urandom_range(0, 3) != 0);
        for (int a = 0; a < 4; a++) acc_done[a] = (credits[a] < MAXO) && ($urandom_range(0, 5) == 0);
        #1;
        if (hold_pend) begin
          check("hold_valid", p_valid, 1);
          check("hold_data", {p_rsp, p_acc}, hold_val);
        end
        if (p_valid && p_ready) begin
          if (exp_q.size() == 0) begin
            fail_now("rand_unexpected", "response with no outstanding request");
          end else begin
            exp = exp_q.pop_front();
            check("rand_rsp", {p_rsp, p_acc}, exp);
            if (exp[7]) begin
              check("rand_credit_avail", credits[exp[1:0]] > 0, 1);
              credits[exp[1:0]]--;
            end
          end
        end
        for (int a = 0; a < 4; a++) if (acc_done[a]) credits[a]++;
        q_took = q_valid && q_ready;
        if (q_took) exp_q.push_back(ref_decode(q_instr));
        hold_pend = p_valid && !p_ready;
        hold_val  = {p_rsp, p_acc};
        cyc++;
        if (cyc >= 500 && !q_valid && exp_q.size() == 0) fin = 1'b1;
        else if (cyc >= 2000) begin
          fail_now("rand_drain", "responses still pending at cycle budget");
          fin = 1'b1;
        end
      end
    end
    acc_done = '0;
    #1;
    check("rand_no_err", credit_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
